// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Used by serial_adder_ctrl, whose optional subtract mode is selected by SERIAL_ADDER_SUB_EN.
package serial_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/fa_bit.sv
// Combinational 1-bit full adder: {co, s} = a + b + ci.
module fa_bit (
    output logic s,
    output logic co,
    input  logic a,
    input  logic b,
    input  logic ci
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder, LSB first, one bit per cycle, IDLE/RUN/DONE control.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input selecting a + ~b + 1 (cin ignored).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [CntW-1:0]  r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_s;
    logic             w_co;

    // Subtraction is folded into the captured operand and carry, so RUN is identical for both.
    always_comb begin
        w_b_in = b;
        w_c_in = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            w_b_in = ~b;
            w_c_in = 1'b1;
        end
`endif
    end

    fa_bit u_fa (
        .s  (w_s),
        .co (w_co),
        .a  (r_a[r_cnt]),
        .b  (r_b[r_cnt]),
        .ci (r_carry)
    );

    // r_acc is cleared on start, so OR-ing the new bit in is a positional write.
    assign w_acc_next = r_acc | (WIDTH'(w_s) << r_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= w_b_in;
                        r_carry <= w_c_in;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_co;
                    if (r_cnt == LastBit) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); subtract cases run when SERIAL_ADDER_SUB_EN is set.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub   = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
        if (ms) return {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
        return {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [W:0] e;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got sum=%0h cout=%0b with nothing expected",
                         sum, cout);
            end else begin
                e = exp_q.pop_front();
                check("result", {23'd0, cout, sum}, {23'd0, e});
            end
        end
    end

    // Leaves the caller 1ns after the edge that accepts start.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic ts, input bit push, input logic [W:0] expv);
        @(negedge clk);
        a     = ta;
        b     = tb;
        cin   = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = ts;
`endif
        start = 1'b1;
        if (push) exp_q.push_back(expv);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for done, then for the DONE->IDLE edge, so the next issue lands in IDLE.
    task automatic wait_done(input string name);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no done within 20 cycles, want done", name);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_cout", 32'(cout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 0xFF + 0x01: busy for 8 cycles, done visible after the 8th edge past the start edge
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 9'h100);
        check("lat_busy0", 32'(busy), 1);
        check("lat_sum_clear", 32'(sum), 0);
        for (int k = 1; k <= int'(W); k++) begin
            @(posedge clk);
            #1;
            if (k < int'(W)) begin
                check("lat_busy", 32'(busy), 1);
                check("lat_nodone", 32'(done), 0);
            end else begin
                check("lat_done", 32'(done), 1);
                check("lat_busy_end", 32'(busy), 0);
            end
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 0);

        // 0x5A + 0x33 + 1 = 0x08E, held after done while inputs wander
        issue(8'h5A, 8'h33, 1'b1, 1'b0, 1'b1, 9'h08E);
        wait_done("add5a");
        a   = 8'hC3;
        b   = 8'h77;
        cin = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hold_sum", 32'(sum), 32'h8E);
        check("hold_cout", 32'(cout), 0);

        // Start pulses with altered operands through RUN and DONE are ignored
        issue(8'h5A, 8'h33, 1'b1, 1'b0, 1'b1, 9'h08E);
        repeat (W + 1) begin
            @(negedge clk);
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
        end
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("repeat_idle", 32'(busy), 0);
        check("repeat_sum", 32'(sum), 32'h8E);
        check("repeat_drained", 32'(exp_q.size()), 0);

        // Reset during RUN cycle 4 aborts with no done
        issue(8'h5A, 8'h33, 1'b1, 1'b0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_sum", 32'(sum), 0);
        check("abort_cout", 32'(cout), 0);
        check("abort_done", 32'(done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("abort_still_idle", 32'(busy), 0);
        issue(8'h10, 8'h20, 1'b0, 1'b0, 1'b1, 9'h030);
        wait_done("after_reset");

`ifdef SERIAL_ADDER_SUB_EN
        issue(8'h05, 8'h07, 1'b1, 1'b1, 1'b1, 9'h0FE);
        wait_done("sub57");
        issue(8'h07, 8'h05, 1'b0, 1'b1, 1'b1, 9'h102);
        wait_done("sub75");
`endif

        // Strided sweep against the behavioural model
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                for (int c = 0; c < 2; c++) begin
                    logic [W-1:0] sa;
                    logic [W-1:0] sb;
                    sa = W'(i * 17);
                    sb = W'(j * 37 + 5);
                    issue(sa, sb, 1'(c), 1'b0, 1'b1, model(sa, sb, 1'(c), 1'b0));
                    wait_done("sweep");
                end
            end
        end

        repeat (3) @(posedge clk);
        check("final_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
